// File: rtl/rd_empty_sync.sv
// Read-domain FIFO status: exports a registered Gray read pointer, synchronizes the write pointer,
// and derives empty/level combinationally (sync lag SYNC_STAGES rclk). No backpressure; underflow is only flagged.
module rd_empty_sync #(
    parameter int SIZE        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic            rclk,
    input  logic            rd_rst,
    input  logic [SIZE:0]   read_ptr,
    input  logic            rd_en,
    input  logic [SIZE:0]   wr_ptr_gray,
    output logic [SIZE:0]   rd_ptr_gray,
    output logic [SIZE:0]   wr_ptr_gray_sync,
    output logic            empty,
    output logic            almost_empty,
    output logic [SIZE:0]   rd_level,
    output logic            rd_underflow
);

    localparam logic [SIZE:0] AE_LIMIT = (SIZE+1)'(AE_THRESH);

    logic [SIZE:0] sync_q [SYNC_STAGES];
    logic [SIZE:0] read_gray;
    logic [SIZE:0] wr_bin;

    assign read_gray = read_ptr ^ (read_ptr >> 1);

    always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr_gray <= '0;
        end else begin
            rd_ptr_gray <= read_gray;
        end
    end

    // Plain flop chain: no logic between stages so each bit resolves metastability independently.
    always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_ptr_gray_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        wr_bin       = '0;
        wr_bin[SIZE] = wr_ptr_gray_sync[SIZE];
        for (int i = SIZE - 1; i >= 0; i--) begin
            wr_bin[i] = wr_bin[i+1] ^ wr_ptr_gray_sync[i];
        end
    end

    // Unregistered so a read_ptr step closes off empty in the same cycle it happens.
    always_comb begin
        if (rd_rst) begin
            empty        = 1'b1;
            rd_level     = '0;
            almost_empty = 1'b1;
        end else begin
            empty        = (read_gray == wr_ptr_gray_sync);
            rd_level     = wr_bin - read_ptr;
            almost_empty = (rd_level <= AE_LIMIT);
        end
    end

    always_ff @(posedge rclk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_underflow <= 1'b0;
        end else if (rd_en && empty) begin
            rd_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rd_empty_sync.sv
// Directed bench for rd_empty_sync with SIZE=8, SYNC_STAGES=2, AE_THRESH=2.
module tb_rd_empty_sync;

    logic       rclk = 1'b0;
    logic       rd_rst;
    logic [8:0] read_ptr;
    logic       rd_en;
    logic [8:0] wr_ptr_gray;
    logic [8:0] rd_ptr_gray;
    logic [8:0] wr_ptr_gray_sync;
    logic       empty;
    logic       almost_empty;
    logic [8:0] rd_level;
    logic       rd_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    rd_empty_sync #(.SIZE(8), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
        .rclk             (rclk),
        .rd_rst           (rd_rst),
        .read_ptr         (read_ptr),
        .rd_en            (rd_en),
        .wr_ptr_gray      (wr_ptr_gray),
        .rd_ptr_gray      (rd_ptr_gray),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .rd_level         (rd_level),
        .rd_underflow     (rd_underflow)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Level must never exceed the FIFO depth.
    always @(negedge rclk) begin
        check("level_range", 32'(rd_level <= 9'd256), 32'd1);
    end

    initial begin
        rd_rst      = 1'b1;
        read_ptr    = 9'h000;
        rd_en       = 1'b0;
        wr_ptr_gray = 9'h000;
        #1;
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_level", 32'(rd_level), 0);
        check("rst_rgray", 32'(rd_ptr_gray), 0);
        check("rst_uf", 32'(rd_underflow), 0);
        tick(); tick();
        rd_rst = 1'b0;

        // Sync latency
        tick();
        wr_ptr_gray = 9'h007;
        #1;
        check("sync_e0", 32'(empty), 1);
        tick();
        check("sync_e1", 32'(empty), 1);
        tick();
        check("sync_e2", 32'(empty), 0);
        check("sync_level", 32'(rd_level), 5);
        check("sync_ae", 32'(almost_empty), 0);
        check("sync_out", 32'(wr_ptr_gray_sync), 32'h007);

        // Drain, with a harmless rd_en while data is present
        read_ptr = 9'd3;
        rd_en    = 1'b1;
        #1;
        check("drain3_level", 32'(rd_level), 2);
        check("drain3_ae", 32'(almost_empty), 1);
        check("drain3_empty", 32'(empty), 0);
        tick();
        rd_en = 1'b0;
        check("no_uf_when_data", 32'(rd_underflow), 0);
        check("drain3_rgray", 32'(rd_ptr_gray), 32'h002);
        read_ptr = 9'd4;
        #1;
        check("drain4_level", 32'(rd_level), 1);
        tick();
        check("drain4_rgray", 32'(rd_ptr_gray), 32'h006);
        read_ptr = 9'd5;
        #1;
        check("drain5_level", 32'(rd_level), 0);
        check("drain5_empty", 32'(empty), 1);
        tick();
        check("drain5_rgray", 32'(rd_ptr_gray), 32'h007);

        // Wrap across 2**(SIZE+1)
        read_ptr    = 9'h1FF;
        wr_ptr_gray = 9'h002;
        tick(); tick();
        check("wrap_level", 32'(rd_level), 4);
        check("wrap_empty", 32'(empty), 0);
        check("wrap_rgray", 32'(rd_ptr_gray), 32'h100);
        read_ptr = 9'h003;
        #1;
        check("wrap_drained", 32'(empty), 1);
        check("wrap_drained_lvl", 32'(rd_level), 0);

        // Full lap
        tick();
        read_ptr    = 9'h000;
        wr_ptr_gray = 9'h180;
        tick(); tick();
        check("full_level", 32'(rd_level), 256);
        check("full_empty", 32'(empty), 0);
        check("full_ae", 32'(almost_empty), 0);

        // Underflow
        read_ptr = 9'h100;
        #1;
        check("uf_empty", 32'(empty), 1);
        check("uf_pre", 32'(rd_underflow), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("uf_set", 32'(rd_underflow), 1);
        tick();
        check("uf_hold", 32'(rd_underflow), 1);
        wr_ptr_gray = 9'h187;
        tick(); tick();
        check("refill_empty", 32'(empty), 0);
        check("refill_level", 32'(rd_level), 5);
        check("uf_after_refill", 32'(rd_underflow), 1);

        // Async reset between edges
        #2;
        rd_rst = 1'b1;
        #1;
        check("arst_empty", 32'(empty), 1);
        check("arst_level", 32'(rd_level), 0);
        check("arst_rgray", 32'(rd_ptr_gray), 0);
        check("arst_uf", 32'(rd_underflow), 0);
        check("arst_sync", 32'(wr_ptr_gray_sync), 0);
        read_ptr    = 9'h000;
        wr_ptr_gray = 9'h007;
        tick(); tick();
        check("arst_hold_sync", 32'(wr_ptr_gray_sync), 0);
        rd_rst = 1'b0;
        #1;
        check("rel_e0", 32'(empty), 1);
        tick();
        check("rel_e1", 32'(empty), 1);
        tick();
        check("rel_e2", 32'(empty), 0);
        check("rel_level", 32'(rd_level), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
